// File: rtl/nf_pwm_cap_pkg.sv
// nf_pwm_cap_pkg: FSM state codes, register map indices and CTRL/STATUS bit positions for nf_pwm_capture.
package nf_pwm_cap_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_WAIT_RISE = 2'd1;
  localparam state_t S_MEAS_HIGH = 2'd2;
  localparam state_t S_MEAS_LOW  = 2'd3;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HIGH   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_VALID    = 0;
  localparam int ST_OVF      = 1;
endpackage

// File: rtl/nf_pwm_cap_sync.sv
// nf_pwm_cap_sync: 2-flop synchronizer, optional 3-sample glitch filter (NF_PWM_CAP_FILTER_EN), edge pulses.
module nf_pwm_cap_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q, lvl;
`ifdef NF_PWM_CAP_FILTER_EN
  logic [1:0] hist_q;
  logic       lvl_q;
  // level moves only once three consecutive synchronized samples agree
  assign lvl = (s2_q == hist_q[0] && s2_q == hist_q[1]) ? s2_q : lvl_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b00;
      lvl_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s2_q};
      lvl_q  <= lvl;
    end
  end
`else
  assign lvl = s2_q;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pwm_i;
      s2_q   <= s1_q;
      prev_q <= lvl;
    end
  end
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;
endmodule

// File: rtl/nf_pwm_capture.sv
// nf_pwm_capture: bus-mapped PWM high-time/period capture with status flags and interrupt.
// Optional glitch filter selected by NF_PWM_CAP_FILTER_EN (inside nf_pwm_cap_sync).
module nf_pwm_capture
  import nf_pwm_cap_pkg::*;
#(
  parameter int cnt_width = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        pwm_in,
  output logic        irq
);
  localparam logic [cnt_width-1:0] CNT_MAX = '1;
  state_t               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d, shadow_q, shadow_d, high_q, high_d, period_q, period_d;
  logic [1:0]           ctrl_q, ctrl_d, status_q, status_d;
  logic                 rise, fall, en, meas, ovf, capture, wr_ctrl, wr_status, unused;

  nf_pwm_cap_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign unused    = ^{addr[31:4], addr[1:0], wd[31:2]};
  assign en        = ctrl_q[CTRL_EN];
  assign meas      = state_q == S_MEAS_HIGH || state_q == S_MEAS_LOW;
  assign wr_ctrl   = we && addr[3:2] == REG_CTRL;
  assign wr_status = we && addr[3:2] == REG_STATUS;
  // a saturated counter poisons the current measurement; it takes priority over edges
  assign ovf       = en && meas && cnt_q == CNT_MAX;
  assign capture   = en && !ovf && state_q == S_MEAS_LOW && rise;

  always_comb begin
    state_d  = !en ? S_IDLE :
               ovf ? S_WAIT_RISE :
               state_q == S_IDLE ? S_WAIT_RISE :
               (rise && state_q != S_MEAS_HIGH) ? S_MEAS_HIGH :
               (fall && state_q == S_MEAS_HIGH) ? S_MEAS_LOW : state_q;
    cnt_d    = (!en || state_q == S_IDLE) ? '0 :
               rise ? cnt_width'(1) :
               cnt_q == CNT_MAX ? cnt_q : cnt_q + cnt_width'(1);
    shadow_d = (en && !ovf && state_q == S_MEAS_HIGH && fall) ? cnt_q : shadow_q;
    high_d   = capture ? shadow_q : high_q;
    period_d = capture ? cnt_q : period_q;
    ctrl_d   = wr_ctrl ? wd[1:0] : ctrl_q;
    status_d = {ovf | (status_q[ST_OVF] & ~(wr_status & wd[ST_OVF])),
                capture | (status_q[ST_VALID] & ~(wr_status & wd[ST_VALID]))};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      high_q   <= '0;
      period_q <= '0;
      ctrl_q   <= 2'b00;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      high_q   <= high_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
    end
  end

  assign rd  = addr[3:2] == REG_CTRL   ? {30'b0, ctrl_q} :
               addr[3:2] == REG_STATUS ? {30'b0, status_q} :
               addr[3:2] == REG_HIGH   ? 32'(high_q) : 32'(period_q);
  assign irq = status_q[ST_VALID] & ctrl_q[CTRL_IRQ_EN];
endmodule

// File: tb/tb_nf_pwm_capture.sv
// tb_nf_pwm_capture: directed register checks plus a randomized waveform scored against a pin-timing model.
module tb_nf_pwm_capture;
  logic        clk = 1'b0, reset = 1'b1, we = 1'b0, pwm = 1'b0, pwm8 = 1'b0;
  logic [31:0] addr = '0, wd = '0, rd, rd8;
  logic        irq, irq8;
  int          cyc = 0, pass_cnt = 0, total_cnt = 0;
  typedef struct {int h; int p;} res_t;
  res_t        q[$];
  bit          en_m = 0, armed = 0, sb_on = 0, drv_done = 0;
  int          rise_cyc = 0, h_m = 0;

  nf_pwm_capture u16 (.clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd), .pwm_in(pwm), .irq(irq));
  nf_pwm_capture #(.cnt_width(8)) u8 (.clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd8), .pwm_in(pwm8), .irq(irq8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint a, input longint e);
    total_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: results are pin-level durations between rises, valid from the second rise after enable
  task automatic set_pwm(input bit v);
    if (v && !pwm) begin
      if (en_m && armed && sb_on) q.push_back('{h_m, cyc - rise_cyc});
      armed    = en_m;
      rise_cyc = cyc;
    end else if (!v && pwm) h_m = cyc - rise_cyc;
    pwm = v;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      set_pwm(1); tick(h); set_pwm(0); tick(l);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    if (a[3:2] == 2'd0) begin
      en_m = d[0];
      if (!d[0]) armed = 0;
    end
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d8);
    addr = a;
    #1;
    d  = rd;
    d8 = rd8;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d8;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(a * 4, d, d8);
      chk("reset_reg", d, 0);
    end
    chk("reset_irq", irq, 0);
    reset = 1'b0;
    tick(2);
    // overflow on the 8-bit instance: constant high never yields a result
    bus_write(0, 1);
    tick(5);
    pwm8 = 1'b1; tick(300);
    bus_read(4, d, d8); chk("ovf_status", d8, 2);
    pwm8 = 1'b0; tick(20);
    bus_read(4, d, d8); chk("ovf_no_valid", d8, 2);
    repeat (3) begin
      pwm8 = 1'b1; tick(10); pwm8 = 1'b0; tick(20);
    end
    bus_read(8, d, d8);  chk("ovf_recover_high", d8, 10);
    bus_read(12, d, d8); chk("ovf_recover_period", d8, 30);
    bus_read(4, d, d8);  chk("ovf_recover_status", d8, 3);
    // basic 30/100 measurement
    wave(30, 70, 1);
    bus_read(4, d, d8); chk("t1_no_valid_yet", d, 0);
    wave(30, 70, 2);
    bus_read(8, d, d8);  chk("t1_high", d, 30);
    bus_read(12, d, d8); chk("t1_period", d, 100);
    bus_read(4, d, d8);  chk("t1_status", d, 1);
    // interrupt enable, w1c, re-assert
    bus_write(0, 3);
    chk("t2_irq_on", irq, 1);
    bus_write(4, 1);
    chk("t2_irq_cleared", irq, 0);
    set_pwm(1); tick(5);
    chk("t2_irq_again", irq, 1);
    tick(15); set_pwm(0); tick(60);
    // clear landing on the capture cycle
    set_pwm(1); tick(2);
    bus_write(4, 1);
    bus_read(4, d, d8);  chk("t4_valid_kept", d[0], 1);
    bus_read(8, d, d8);  chk("t4_high", d, 20);
    bus_read(12, d, d8); chk("t4_period", d, 80);
    // abort mid-low, then re-enable with a 50/200 wave
    tick(17); set_pwm(0); tick(20);
    bus_write(0, 0);
    tick(5);
    set_pwm(1); tick(10); set_pwm(0); tick(10);
    bus_read(8, d, d8);  chk("t5_high_kept", d, 20);
    bus_read(12, d, d8); chk("t5_period_kept", d, 80);
    bus_read(0, d, d8);  chk("t5_ctrl", d, 0);
    bus_write(0, 3);
    bus_write(4, 3);
    tick(5);
    wave(50, 150, 2);
    set_pwm(1); tick(5);
    bus_read(8, d, d8);  chk("t5_high_new", d, 50);
    bus_read(12, d, d8); chk("t5_period_new", d, 200);
    tick(45); set_pwm(0); tick(30);
    bus_write(4, 3);
    // randomized run scored through irq-driven monitor
    sb_on = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          set_pwm(1); tick($urandom_range(40, 4));
          set_pwm(0); tick($urandom_range(40, 8));
        end
        set_pwm(1); tick(10);
        drv_done = 1;
      end
      begin
        logic [31:0] h, p, x;
        res_t r;
        for (int c = 0; c < 20000 && !(drv_done && q.size() == 0); c++) begin
          @(negedge clk);
          if (irq) begin
            bus_read(8, h, x);
            bus_read(12, p, x);
            bus_write(4, 1);
            if (q.size() == 0) chk("sb_unexpected_result", 1, 0);
            else begin
              r = q.pop_front();
              chk("sb_high", h, r.h);
              chk("sb_period", p, r.p);
            end
          end
        end
        chk("sb_drain", q.size(), 0);
      end
    join
    // asynchronous reset mid-measurement
    addr = 8;
    #3 reset = 1'b1;
    #1;
    chk("async_reset_high", rd, 0);
    chk("async_reset_irq", irq, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
